univ_shift_reg: RTL and testbench
=================================

# univ_shift_reg

Parametrised universal shift register that generalises the fixed 4-stage serial-in/serial-out chain. It provides WIDTH stages with bidirectional shift, parallel load, hold and clock enable, plus a shift counter that flags each completed word. It serves as the common serial/parallel converter for SISO, SIPO, PISO and PIPO use across the design.

## Interface
- WIDTH, 4, number of register stages; legal range is WIDTH >= 2.
- CW, $clog2(WIDTH+1), width of the shift counter. It is derived and must not be overridden.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low; sampled on the rising edge of clk.
- en  in  1  clock enable; 0 freezes all state.
- mode  in  2  operation select: 00 HOLD, 01 SHIFT_UP, 10 SHIFT_DN, 11 LOAD.
- sin_lo  in  1  serial input entering stage 0 during SHIFT_UP.
- sin_hi  in  1  serial input entering stage WIDTH-1 during SHIFT_DN.
- pin  in  WIDTH  parallel load data.
- pout  out  WIDTH  register contents q.
- sout_hi  out  1  q[WIDTH-1]; serial output for SHIFT_UP.
- sout_lo  out  1  q[0]; serial output for SHIFT_DN.
- shift_cnt  out  CW  number of shifts since the last load, reset or word completion.
- word_done  out  1  one-cycle pulse marking that WIDTH shifts have completed.

## Operation
- Reset: when rst_n=0 at a clk edge, q=0, shift_cnt=0 and word_done=0. Reset takes priority over en and mode, including in the middle of a word.
- en=0: q and shift_cnt hold; word_done=0 on that edge.
- en=1, by mode:
  - HOLD: q and shift_cnt are unchanged.
  - SHIFT_UP: q <= {q[WIDTH-2:0], sin_lo}.
  - SHIFT_DN: q <= {sin_hi, q[WIDTH-1:1]}.
  - LOAD: q <= pin and shift_cnt <= 0.
- Counter, per enabled SHIFT_UP or SHIFT_DN edge:
  - If shift_cnt == WIDTH-1: shift_cnt <= 0 and word_done <= 1.
  - Otherwise: shift_cnt <= shift_cnt+1 and word_done <= 0.
- On every other edge, word_done <= 0.
- Changing direction mid-word does not clear shift_cnt; shifts in either direction accumulate.
- shift_cnt never reaches WIDTH; it wraps from WIDTH-1 to 0.
- With WIDTH=4 and a fixed mode of SHIFT_UP with en=1, the block behaves as a 4-stage SISO delay line: sin_lo appears on sout_hi 4 edges later.
- All outputs are direct register outputs. There is no combinational path from any input to any output.

## Timing
- Latency:
  - Parallel load appears on pout 1 cycle after the LOAD edge.
  - SISO latency is WIDTH edges from sin_lo to sout_hi, or from sin_hi to sout_lo.
  - SIPO: a full word is valid on pout in the same cycle that word_done=1.
- word_done is high for exactly one cycle: the cycle after the edge that performed the WIDTH-th shift. It repeats every WIDTH shifts under continuous shifting.
- Simultaneous events:
  - LOAD on the edge that would otherwise be the WIDTH-th shift produces no word_done, because LOAD is not a shift.
  - en=0 on that edge defers the count.
- Reset mid-word discards the partial count; the next word starts at shift_cnt=0.
- Serial inputs are sampled only on edges that use them. sin_hi is ignored in SHIFT_UP, and sin_lo is ignored in SHIFT_DN.

## Test plan
- Reset: drive rst_n=0 for 2 edges with mode=11 and pin=all ones -> pout=0, shift_cnt=0 and word_done=0 after each edge. Release rst_n -> the next edge loads pin.
- SISO, WIDTH=4, en=1, mode=01: sin_lo sequence 1,0,1,1,0,0,0,0 -> sout_hi shows the same sequence delayed by 4 edges. word_done pulses after edges 4 and 8, and shift_cnt follows 1,2,3,0.
- PISO: LOAD pin=4'b1011, then 4 SHIFT_DN edges with sin_hi=0 -> sout_lo=1,1,0,1 over successive cycles, then pout=0. word_done=1 only in the cycle after the 4th shift.
- Hold and enable: LOAD 4'b0110, then drive HOLD for 3 edges, then en=0 with mode=01 for 3 edges -> pout stays 0110 and shift_cnt stays 0 throughout.
- Mixed direction and load: LOAD 4'b1000, do 2 SHIFT_UP edges with sin_lo=1 (pout=0011, shift_cnt=2), then 1 SHIFT_DN edge with sin_hi=1 (pout=1001, shift_cnt=3), then LOAD 4'b0101 -> shift_cnt=0 and no word_done.
- Reset mid-word plus WIDTH=8 instance: do 5 SHIFT_UP edges, then one edge with rst_n=0 -> pout=0 and shift_cnt=0. Then do 8 more shifts -> word_done pulses once, after the 8th.

Source files
------------

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - parametrised universal shift register with word-completion counter
// Bidirectional shift, parallel load, hold and clock enable; every output is a flop output.
module univ_shift_reg #(
    parameter  int WIDTH = 4,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_lo,
    input  logic             sin_hi,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] pout,
    output logic             sout_hi,
    output logic             sout_lo,
    output logic [CW-1:0]    shift_cnt,
    output logic             word_done
);

    localparam logic [1:0] MODE_HOLD     = 2'b00;
    localparam logic [1:0] MODE_SHIFT_UP = 2'b01;
    localparam logic [1:0] MODE_SHIFT_DN = 2'b10;
    localparam logic [1:0] MODE_LOAD     = 2'b11;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             is_shift;

    always_comb begin
        q_d      = q_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        is_shift = 1'b0;
        if (en) begin
            case (mode)
                MODE_HOLD: q_d = q_q;
                MODE_SHIFT_UP: begin
                    q_d      = {q_q[WIDTH-2:0], sin_lo};
                    is_shift = 1'b1;
                end
                MODE_SHIFT_DN: begin
                    q_d      = {sin_hi, q_q[WIDTH-1:1]};
                    is_shift = 1'b1;
                end
                MODE_LOAD: begin
                    q_d   = pin;
                    cnt_d = '0;
                end
                default: q_d = q_q;
            endcase
        end
        // Shifts in either direction share one count; it wraps at WIDTH-1.
        if (is_shift) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q    <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign pout      = q_q;
    assign sout_hi   = q_q[WIDTH-1];
    assign sout_lo   = q_q[0];
    assign shift_cnt = cnt_q;
    assign word_done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - directed self-checking bench for univ_shift_reg
// Covers a WIDTH=4 instance and a WIDTH=8 instance sharing one clock.
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en, sin_lo, sin_hi;
    logic [1:0] mode;
    logic [3:0] pin;
    logic [3:0] pout;
    logic       sout_hi, sout_lo, word_done;
    logic [2:0] shift_cnt;

    logic       rst_n8, en8, sin_lo8, sin_hi8;
    logic [1:0] mode8;
    logic [7:0] pin8;
    logic [7:0] pout8;
    logic       sout_hi8, sout_lo8, word_done8;
    logic [3:0] shift_cnt8;

    univ_shift_reg #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .sin_lo(sin_lo), .sin_hi(sin_hi), .pin(pin),
        .pout(pout), .sout_hi(sout_hi), .sout_lo(sout_lo),
        .shift_cnt(shift_cnt), .word_done(word_done)
    );

    univ_shift_reg #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n8), .en(en8), .mode(mode8),
        .sin_lo(sin_lo8), .sin_hi(sin_hi8), .pin(pin8),
        .pout(pout8), .sout_hi(sout_hi8), .sout_lo(sout_lo8),
        .shift_cnt(shift_cnt8), .word_done(word_done8)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step4(input logic r, input logic e, input logic [1:0] m,
                         input logic sl, input logic sh, input logic [3:0] p);
        rst_n = r; en = e; mode = m; sin_lo = sl; sin_hi = sh; pin = p;
        @(posedge clk);
        #1;
    endtask

    task automatic step8(input logic r, input logic e, input logic [1:0] m, input logic sl);
        rst_n8 = r; en8 = e; mode8 = m; sin_lo8 = sl; sin_hi8 = 1'b0; pin8 = 8'hA5;
        @(posedge clk);
        #1;
    endtask

    logic [0:7] sin_v  = 8'b1011_0000;
    logic [0:7] sout_v = 8'b1111_0110;
    logic [0:7] wd_v   = 8'b0001_0001;
    logic [0:3] piso_v = 4'b1010;

    initial begin
        rst_n = 1'b0; en = 1'b1; mode = 2'b11; sin_lo = 1'b0; sin_hi = 1'b0; pin = 4'hF;
        rst_n8 = 1'b0; en8 = 1'b1; mode8 = 2'b00; sin_lo8 = 1'b0; sin_hi8 = 1'b0; pin8 = 8'h00;

        // reset held for two edges while LOAD of all ones is requested
        for (int i = 0; i < 2; i++) begin
            step4(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 4'hF);
            chk("rst_pout", pout, 4'h0);
            chk("rst_cnt", shift_cnt, 3'd0);
            chk("rst_wd", word_done, 1'b0);
        end
        step4(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 4'hF);
        chk("rel_load_pout", pout, 4'hF);

        // SISO delay line
        for (int k = 0; k < 8; k++) begin
            step4(1'b1, 1'b1, 2'b01, sin_v[k], ~sin_v[k], 4'h0);
            chk($sformatf("siso_sout_e%0d", k + 1), sout_hi, sout_v[k]);
            chk($sformatf("siso_wd_e%0d", k + 1), word_done, wd_v[k]);
            chk($sformatf("siso_cnt_e%0d", k + 1), shift_cnt, 3'((k + 1) % 4));
        end
        chk("siso_pout_end", pout, 4'b0000);

        // PISO
        step4(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 4'b1011);
        chk("piso_load_pout", pout, 4'b1011);
        chk("piso_load_sout", sout_lo, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step4(1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 4'h0);
            chk($sformatf("piso_sout_e%0d", k + 1), sout_lo, piso_v[k]);
            chk($sformatf("piso_wd_e%0d", k + 1), word_done, k == 3);
        end
        chk("piso_pout_end", pout, 4'b0000);
        step4(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 4'h0);
        chk("piso_wd_after", word_done, 1'b0);

        // hold and enable
        step4(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 4'b0110);
        for (int k = 0; k < 6; k++) begin
            if (k < 3) step4(1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 4'hF);
            else       step4(1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 4'hF);
            chk($sformatf("hold_pout_%0d", k), pout, 4'b0110);
            chk($sformatf("hold_cnt_%0d", k), shift_cnt, 3'd0);
            chk($sformatf("hold_wd_%0d", k), word_done, 1'b0);
        end

        // mixed direction then load on what would be the last shift
        step4(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 4'b1000);
        step4(1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 4'h0);
        step4(1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 4'h0);
        chk("mix_up_pout", pout, 4'b0011);
        chk("mix_up_cnt", shift_cnt, 3'd2);
        step4(1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 4'h0);
        chk("mix_dn_pout", pout, 4'b1001);
        chk("mix_dn_cnt", shift_cnt, 3'd3);
        step4(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 4'b0101);
        chk("mix_load_pout", pout, 4'b0101);
        chk("mix_load_cnt", shift_cnt, 3'd0);
        chk("mix_load_wd", word_done, 1'b0);

        // en=0 on the would-be last shift defers the word
        for (int k = 0; k < 3; k++) step4(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 4'h0);
        step4(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 4'h0);
        chk("defer_cnt", shift_cnt, 3'd3);
        chk("defer_wd", word_done, 1'b0);
        step4(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 4'h0);
        chk("defer_done_wd", word_done, 1'b1);
        chk("defer_done_cnt", shift_cnt, 3'd0);

        // WIDTH=8: partial word, reset, then a full word
        for (int k = 0; k < 5; k++) step8(1'b1, 1'b1, 2'b01, 1'b1);
        chk("w8_part_pout", pout8, 8'h1F);
        chk("w8_part_cnt", shift_cnt8, 4'd5);
        step8(1'b0, 1'b1, 2'b01, 1'b1);
        chk("w8_rst_pout", pout8, 8'h00);
        chk("w8_rst_cnt", shift_cnt8, 4'd0);
        for (int k = 0; k < 8; k++) begin
            step8(1'b1, 1'b1, 2'b01, 1'b1);
            chk($sformatf("w8_wd_e%0d", k + 1), word_done8, k == 7);
        end
        chk("w8_full_pout", pout8, 8'hFF);
        chk("w8_full_cnt", shift_cnt8, 4'd0);
        step8(1'b1, 1'b1, 2'b00, 1'b0);
        chk("w8_wd_after", word_done8, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
